stickit_bcd: RTL

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) feeding the 32-bit VALUE input of the StickIt! LED-digit scanner. It turns a binary count into eight packed BCD nibbles, so the 8-digit display shows decimal instead of hex. The result register holds the last completed conversion and drives the display continuously while a new conversion runs.

---
 rtl/stickit_pkg.sv | 11 +
 rtl/stickit_bcd_adj.sv | 8 +
 rtl/stickit_bcd.sv | 136 +++++++++++++
 3 files changed

// File: rtl/stickit_pkg.sv
// Shared constants and state encoding for the StickIt! binary-to-BCD converter.
package stickit_pkg;
    localparam int          NUM_DIGITS      = 8;
    localparam logic [31:0] MAX_DEC         = 32'd99_999_999;
    localparam logic [31:0] BCD_OVF_PATTERN = 32'hEEEE_EEEE;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/stickit_bcd_adj.sv
// One BCD digit corrector for the double-dabble step: digits of 5..9 get +3 so the
// following left shift carries correctly into the next decimal digit.
module stickit_bcd_adj (
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);
    assign q_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;
endmodule

// File: rtl/stickit_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) for the
// StickIt! display VALUE input. Define STICKIT_BCD_OVF_EN to flag values above 99,999,999.
module stickit_bcd
    import stickit_pkg::*;
#(
    parameter int WIDTH = 27
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [31:0]      BCD,
    output logic             OVF
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [31:0]      scratch_q, scratch_d;
    logic [31:0]      scratch_adj;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [31:0]      bcd_q, bcd_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            stickit_bcd_adj u_adj (
                .d_i (scratch_q[4*gi +: 4]),
                .q_o (scratch_adj[4*gi +: 4])
            );
        end
    endgenerate

`ifdef STICKIT_BCD_OVF_EN
    logic ovf_in;
    logic ovf_flag_q, ovf_flag_d;
    logic ovf_q, ovf_d;

    // Only a 27-bit (or wider) input can reach 10^8.
    generate
        if (WIDTH >= 27) begin : g_ovf_cmp
            assign ovf_in = (32'(BIN) > MAX_DEC);
        end else begin : g_ovf_none
            assign ovf_in = 1'b0;
        end
    endgenerate
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
`ifdef STICKIT_BCD_OVF_EN
        ovf_flag_d = ovf_flag_q;
        ovf_d      = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (START) begin
                    shift_d   = BIN;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH - 1);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
`ifdef STICKIT_BCD_OVF_EN
                    ovf_flag_d = ovf_in;
`endif
                end
            end
            SHIFT: begin
                // The carry out of digit 7 is dropped, which leaves BIN mod 10^8.
                scratch_d = {scratch_adj[30:0], shift_q[WIDTH-1]};
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    bcd_d   = scratch_d;
`ifdef STICKIT_BCD_OVF_EN
                    if (ovf_flag_q) begin
                        bcd_d = BCD_OVF_PATTERN;
                    end
                    ovf_d = ovf_flag_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
`ifdef STICKIT_BCD_OVF_EN
            ovf_flag_q <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
`ifdef STICKIT_BCD_OVF_EN
            ovf_flag_q <= ovf_flag_d;
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign BCD  = bcd_q;
`ifdef STICKIT_BCD_OVF_EN
    assign OVF  = ovf_q;
`else
    assign OVF  = 1'b0;
`endif
endmodule
